envelope_ctrl: RTL and testbench

ENVELOPE_CTRL -- requirements
Module: envelope_ctrl

---
 rtl/envelope_ctrl.sv | 142 ++++++++++++++
 tb/tb_envelope_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/envelope_ctrl.sv
// ADSR envelope sequencer: steps a registered amplitude on each sample tick.
// The note frequency word is captured at note-on and handed to the synth datapath.
//
// state   | meaning
// IDLE    | no note, envelope held at zero
// ATTACK  | ramp up toward the peak captured at note-on
// DECAY   | ramp down toward the captured sustain level
// SUSTAIN | hold the level until the gate falls
// RELEASE | ramp down to zero, pulse done on arrival
module envelope_ctrl #(
    parameter int AMP_W  = 16,
    parameter int FREQ_W = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              sample_tick,
    input  logic              gate,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic [AMP_W-1:0]  amp_peak,
    input  logic [AMP_W-1:0]  attack_rate,
    input  logic [AMP_W-1:0]  decay_rate,
    input  logic [AMP_W-1:0]  release_rate,
    input  logic [AMP_W-1:0]  sustain_level,
    output logic [FREQ_W-1:0] freq_out,
    output logic [AMP_W-1:0]  amp_out,
    output logic [2:0]        state_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [AMP_W-1:0]   env_q, env_d;
    logic [AMP_W-1:0]   peak_q, peak_d;
    logic [AMP_W-1:0]   sus_q, sus_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic               gate_q;
    logic               done_q, done_d;

    logic               rise, fall;
    logic [AMP_W:0]     atk_sum;
    logic [AMP_W:0]     dec_floor;

    assign rise      = gate & ~gate_q;
    assign fall      = ~gate & gate_q;
    // One extra bit so the step comparisons can never wrap.
    assign atk_sum   = {1'b0, env_q} + {1'b0, attack_rate};
    assign dec_floor = {1'b0, sus_q} + {1'b0, decay_rate};

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= S_IDLE;
            env_q   <= '0;
            peak_q  <= '0;
            sus_q   <= '0;
            freq_q  <= '0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            peak_q  <= peak_d;
            sus_q   <= sus_d;
            freq_q  <= freq_d;
            gate_q  <= gate;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        peak_d  = peak_q;
        sus_d   = sus_q;
        freq_d  = freq_q;
        done_d  = 1'b0;
        // Gate edges win over the tick; the envelope resumes from its current value.
        if (rise) begin
            state_d = S_ATTACK;
            freq_d  = freq_in;
            peak_d  = amp_peak;
            sus_d   = (sustain_level < amp_peak) ? sustain_level : amp_peak;
        end else if (fall) begin
            case (state_q)
                S_ATTACK, S_DECAY, S_SUSTAIN: state_d = S_RELEASE;
                S_IDLE, S_RELEASE:            state_d = state_q;
                default:                      state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: env_d = '0;
                S_ATTACK: begin
                    if (sample_tick) begin
                        if (attack_rate == '0 || atk_sum >= {1'b0, peak_q}) begin
                            env_d   = peak_q;
                            state_d = S_DECAY;
                        end else begin
                            env_d = atk_sum[AMP_W-1:0];
                        end
                    end
                end
                S_DECAY: begin
                    if (sample_tick) begin
                        if (decay_rate == '0 || {1'b0, env_q} <= dec_floor) begin
                            env_d   = sus_q;
                            state_d = S_SUSTAIN;
                        end else begin
                            env_d = env_q - decay_rate;
                        end
                    end
                end
                S_SUSTAIN: env_d = env_q;
                S_RELEASE: begin
                    if (sample_tick) begin
                        if (release_rate == '0 || env_q <= release_rate) begin
                            env_d   = '0;
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            env_d = env_q - release_rate;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign freq_out  = freq_q;
    assign amp_out   = env_q;
    assign state_out = state_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_envelope_ctrl.sv
// Bench for envelope_ctrl: a vector table run through an expectation queue,
// then hand-written reset sequences.
module tb_envelope_ctrl;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        gate = 1'b0;
    logic [31:0] freq_in = '0;
    logic [15:0] amp_peak = '0, attack_rate = '0, decay_rate = '0;
    logic [15:0] release_rate = '0, sustain_level = '0;
    logic [31:0] freq_out;
    logic [15:0] amp_out;
    logic [2:0]  state_out;
    logic        busy, done;

    envelope_ctrl #(.AMP_W(16), .FREQ_W(32)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .sample_tick(sample_tick),
        .gate(gate), .freq_in(freq_in), .amp_peak(amp_peak),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .release_rate(release_rate), .sustain_level(sustain_level),
        .freq_out(freq_out), .amp_out(amp_out), .state_out(state_out),
        .busy(busy), .done(done)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic        g, t;
        logic [15:0] peak, atk, dec, rel, sus;
        logic [31:0] freq;
        logic [15:0] e_amp;
        logic [2:0]  e_st;
        logic        e_done;
        logic [31:0] e_freq;
    } vec_t;

    vec_t vecs[$];
    vec_t expq[$];
    int checks = 0;
    int errors = 0;

    logic [15:0] k_peak, k_atk, k_dec, k_rel, k_sus;
    logic [31:0] k_freq, e_freq;
    logic        cur_g;
    int          last_amp, last_st;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic g, input logic t, input int amp, input int st, input logic dn);
        vec_t v;
        v.g = g; v.t = t;
        v.peak = k_peak; v.atk = k_atk; v.dec = k_dec; v.rel = k_rel; v.sus = k_sus;
        v.freq = k_freq;
        v.e_amp = amp[15:0]; v.e_st = st[2:0]; v.e_done = dn; v.e_freq = e_freq;
        return v;
    endfunction

    task automatic add(input logic g, input logic t, input int amp, input int st, input logic dn);
        vecs.push_back(mk(g, t, amp, st, dn));
        last_amp = amp; last_st = st; cur_g = g;
    endtask

    // Three quiet cycles, then one tick cycle: a tick every fourth clock.
    task automatic tk(input int amp, input int st, input logic dn);
        for (int i = 0; i < 3; i++) add(cur_g, 1'b0, last_amp, last_st, 1'b0);
        add(cur_g, 1'b1, amp, st, dn);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge clk_clk);
        gate = v.g; sample_tick = v.t;
        amp_peak = v.peak; attack_rate = v.atk; decay_rate = v.dec;
        release_rate = v.rel; sustain_level = v.sus; freq_in = v.freq;
        expq.push_back(v);
        @(posedge clk_clk);
        #1;
        if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: expectation queue empty");
        end else begin
            e = expq.pop_front();
            check("amp_out", {16'h0, amp_out}, {16'h0, e.e_amp});
            check("state_out", {29'h0, state_out}, {29'h0, e.e_st});
            check("done", {31'h0, done}, {31'h0, e.e_done});
            check("busy", {31'h0, busy}, {31'h0, (e.e_st != 3'd0)});
            check("freq_out", freq_out, e.e_freq);
        end
    endtask

    initial begin
        k_peak = 16'd1000; k_atk = 16'd300; k_dec = 16'd250; k_rel = 16'd150; k_sus = 16'd400;
        k_freq = 32'h1234_5678; e_freq = 32'h1234_5678;
        cur_g = 1'b0; last_amp = 0; last_st = 0;

        // Basic ADSR, rise coincident with a tick
        add(1, 1, 0, 1, 0);
        k_freq = 32'hDEAD_BEEF;
        tk(300, 1, 0); tk(600, 1, 0); tk(900, 1, 0); tk(1000, 2, 0);
        tk(750, 2, 0); tk(500, 2, 0); tk(400, 3, 0);
        k_sus = 16'd100; k_peak = 16'd50;
        tk(400, 3, 0);
        add(0, 1, 400, 4, 0);
        tk(250, 4, 0); tk(100, 4, 0); tk(0, 0, 1); tk(0, 0, 0);

        // Retrigger from RELEASE with attack rate 0
        k_peak = 16'd1000; k_atk = 16'd300; k_sus = 16'd400; k_dec = 16'd250; k_rel = 16'd500;
        e_freq = 32'hDEAD_BEEF;
        add(1, 0, 0, 1, 0);
        tk(300, 1, 0); tk(600, 1, 0); tk(900, 1, 0); tk(1000, 2, 0); tk(750, 2, 0);
        add(0, 0, 750, 4, 0);
        tk(250, 4, 0);
        k_atk = 16'd0; k_freq = 32'hCAFE_F00D; e_freq = 32'hCAFE_F00D;
        add(1, 0, 250, 1, 0);
        tk(1000, 2, 0);

        // Saturating attack, envelope above peak, sustain above peak
        add(0, 0, 1000, 4, 0);
        k_peak = 16'h8000; k_atk = 16'd0; k_sus = 16'hFFFF;
        add(1, 0, 1000, 1, 0);
        tk(32'h8000, 2, 0); tk(32'h8000, 3, 0);
        add(0, 0, 32'h8000, 4, 0);
        k_peak = 16'hFFFF; k_atk = 16'hFFF0;
        add(1, 0, 32'h8000, 1, 0);
        tk(32'hFFFF, 2, 0);
        add(0, 0, 32'hFFFF, 4, 0);
        k_peak = 16'd3000; k_sus = 16'd5000; k_atk = 16'd0;
        add(1, 0, 32'hFFFF, 1, 0);
        tk(3000, 2, 0); tk(3000, 3, 0);

        // Decay rate 0 and release rate 0 jump straight to their targets
        add(0, 0, 3000, 4, 0);
        k_peak = 16'd4000; k_sus = 16'd1000; k_dec = 16'd0;
        add(1, 0, 3000, 1, 0);
        tk(4000, 2, 0); tk(1000, 3, 0);
        add(0, 0, 1000, 4, 0);
        k_rel = 16'd0;
        tk(0, 0, 1);
        add(0, 0, 0, 0, 0);

        // Reset state
        #2;
        check("rst_amp", {16'h0, amp_out}, 32'h0);
        check("rst_state", {29'h0, state_out}, 32'h0);
        check("rst_freq", freq_out, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        @(negedge clk_clk);
        reset_reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Async reset mid-DECAY at 700, then gate high across reset release
        k_peak = 16'd1000; k_atk = 16'd0; k_sus = 16'd400; k_dec = 16'd300; k_rel = 16'd100;
        k_freq = 32'h0BAD_F00D; e_freq = 32'h0BAD_F00D;
        run_vec(mk(1, 0, 0, 1, 0));
        run_vec(mk(1, 1, 1000, 2, 0));
        run_vec(mk(1, 1, 700, 2, 0));
        #2;
        reset_reset = 1'b1;
        #1;
        check("async_amp", {16'h0, amp_out}, 32'h0);
        check("async_state", {29'h0, state_out}, 32'h0);
        check("async_freq", freq_out, 32'h0);
        check("async_busy", {31'h0, busy}, 32'h0);
        check("async_done", {31'h0, done}, 32'h0);
        @(posedge clk_clk);
        #1;
        check("held_state", {29'h0, state_out}, 32'h0);
        check("held_done", {31'h0, done}, 32'h0);
        @(negedge clk_clk);
        sample_tick = 1'b0;
        reset_reset = 1'b0;
        @(posedge clk_clk);
        #1;
        check("rel_rise_state", {29'h0, state_out}, 32'h1);
        check("rel_rise_freq", freq_out, 32'h0BAD_F00D);
        check("rel_rise_amp", {16'h0, amp_out}, 32'h0);
        run_vec(mk(1, 1, 1000, 2, 0));

        if (expq.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: %0d expectations left", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
